// File: rtl/literal_accumulator.sv
// Accumulates 5-bit literal groups (continuation + nibble), several per beat, into a
// VALUE_W-bit value; reports groups consumed per beat and holds the result for handoff.
module literal_accumulator #(
   parameter int VALUE_W          = 64,
   parameter int GROUPS_PER_CYCLE = 4,
   parameter int COUNT_W          = 8,
   localparam int TAKE_W          = $clog2(GROUPS_PER_CYCLE + 1)
) (
   input  logic                          clk,
   input  logic                          resetB,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [5*GROUPS_PER_CYCLE-1:0] in_bits,
   output logic [TAKE_W-1:0]             in_take,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [VALUE_W-1:0]            value,
   output logic [COUNT_W-1:0]            bits_total,
   output logic                          overflow
);

   localparam int NIBBLES = VALUE_W / 4;
   // Nibble counter is wide enough that one more beat past NIBBLES is always representable.
   localparam int NC_W    = $clog2(NIBBLES + GROUPS_PER_CYCLE + 1) + 1;
   localparam int SUM_W   = COUNT_W + 8;

   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   state_t               state_q, state_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic [COUNT_W-1:0]   bits_q, bits_d;
   logic                 ovf_q, ovf_d;
   logic [NC_W-1:0]      ncnt_q, ncnt_d;

   logic [GROUPS_PER_CYCLE-1:0] cont;
   logic [3:0]                  nib [GROUPS_PER_CYCLE];

   generate
      for (genvar gi = 0; gi < GROUPS_PER_CYCLE; gi++) begin : g_split
         assign cont[gi] = in_bits[5*(GROUPS_PER_CYCLE-gi)-1];
         assign nib[gi]  = in_bits[5*(GROUPS_PER_CYCLE-gi)-2 -: 4];
      end
   endgenerate

   logic              term_found;
   logic [TAKE_W-1:0] take_raw;
   logic [VALUE_W-1:0] shifted;
   logic [SUM_W-1:0]  bits_sum;
   logic [COUNT_W-1:0] bits_sat;
   logic [NC_W:0]     ncnt_sum;
   logic [NC_W-1:0]   ncnt_sat;

   // Lowest-index group with a clear continuation bit terminates the literal.
   always_comb begin
      term_found = 1'b0;
      take_raw   = TAKE_W'(GROUPS_PER_CYCLE);
      for (int g = GROUPS_PER_CYCLE - 1; g >= 0; g--) begin
         if (!cont[g]) begin
            term_found = 1'b1;
            take_raw   = TAKE_W'(g + 1);
         end
      end
   end

   always_comb begin
      shifted = value_q;
      for (int g = 0; g < GROUPS_PER_CYCLE; g++) begin
         if (g < int'(take_raw)) begin
            shifted = (shifted << 4) | VALUE_W'(nib[g]);
         end
      end

      bits_sum = SUM_W'(bits_q) + SUM_W'(take_raw) * SUM_W'(5);
      if (bits_sum > SUM_W'({COUNT_W{1'b1}})) begin
         bits_sat = '1;
      end else begin
         bits_sat = bits_sum[COUNT_W-1:0];
      end

      ncnt_sum = (NC_W+1)'(ncnt_q) + (NC_W+1)'(take_raw);
      if (ncnt_sum > (NC_W+1)'({NC_W{1'b1}})) begin
         ncnt_sat = '1;
      end else begin
         ncnt_sat = ncnt_sum[NC_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      bits_d  = bits_q;
      ovf_d   = ovf_q;
      ncnt_d  = ncnt_q;
      in_take = '0;

      if (flush) begin
         state_d = ST_ACCUM;
         value_d = '0;
         bits_d  = '0;
         ovf_d   = 1'b0;
         ncnt_d  = '0;
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (in_valid) begin
                  in_take = take_raw;
                  value_d = shifted;
                  bits_d  = bits_sat;
                  ncnt_d  = ncnt_sat;
                  ovf_d   = ovf_q | (ncnt_sat > NC_W'(NIBBLES));
                  if (term_found) begin
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state_d = ST_ACCUM;
                  value_d = '0;
                  bits_d  = '0;
                  ovf_d   = 1'b0;
                  ncnt_d  = '0;
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetB) begin
      if (!resetB) begin
         state_q <= ST_ACCUM;
         value_q <= '0;
         bits_q  <= '0;
         ovf_q   <= 1'b0;
         ncnt_q  <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         bits_q  <= bits_d;
         ovf_q   <= ovf_d;
         ncnt_q  <= ncnt_d;
      end
   end

   assign in_ready   = (state_q == ST_ACCUM);
   assign out_valid  = (state_q == ST_HOLD);
   assign value      = value_q;
   assign bits_total = bits_q;
   assign overflow   = ovf_q;

endmodule
